// File: rtl/fetch_defs.sv
// Shared definitions for the fetch front end: FSM encoding, default widths and the
// instruction value presented while nothing has been fetched.
package fetch_defs;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned INST_W_DEF = 32;
    localparam logic [31:0] NOP        = 32'h0;

    typedef enum logic [1:0] {
        StRst  = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// Output register plus one-entry skid buffer for fetched {instruction, pc} pairs.
// The producer guarantees a response never arrives while both entries are occupied.
module fetch_skid_buf
    import fetch_defs::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [INST_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_pc_i,
    output logic              out_valid_o,
    output logic [INST_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_pc_o,
    input  logic              out_ready_i,
    output logic              skid_valid_o
);

    logic              out_v_q, out_v_d;
    logic [INST_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              skid_v_q, skid_v_d;
    logic [INST_W-1:0] skid_data_q, skid_data_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    always_comb begin
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        out_pc_d    = out_pc_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        if (flush_i) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
        end else if (!out_v_q || out_ready_i) begin
            if (skid_v_q) begin
                // Oldest entry first: skid moves up, new response backfills the skid.
                out_data_d = skid_data_q;
                out_pc_d   = skid_pc_q;
                skid_v_d   = in_valid_i;
                if (in_valid_i) begin
                    skid_data_d = in_data_i;
                    skid_pc_d   = in_pc_i;
                end
            end else begin
                out_v_d = in_valid_i;
                if (in_valid_i) begin
                    out_data_d = in_data_i;
                    out_pc_d   = in_pc_i;
                end
            end
        end else if (in_valid_i) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data_i;
            skid_pc_d   = in_pc_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_v_q     <= 1'b0;
            out_data_q  <= INST_W'(NOP);
            out_pc_q    <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= INST_W'(NOP);
            skid_pc_q   <= '0;
        end else begin
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            out_pc_q    <= out_pc_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign out_valid_o  = out_v_q;
    assign out_data_o   = out_data_q;
    assign out_pc_o     = out_pc_q;
    assign skid_valid_o = skid_v_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues reads to a synchronous imem and
// hands {instruction, pc} to decode through a skid-buffered valid/ready port.
module fetch_stage
    import fetch_defs::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [INST_W-1:0] q_imem,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_pc_q;
    logic [31:0]       count_q;

    logic skid_v;
    logic redirect_en;
    logic resp_valid;
    logic issue;
    logic transfer;

    assign redirect_en = redirect_valid && (state_q != StRst);
    // A response landing in the redirect cycle belongs to the squashed path.
    assign resp_valid  = pend_q && !redirect_en;
    assign transfer    = inst_valid && inst_ready;
    // Stop issuing once the in-flight response would have nowhere to go next cycle.
    assign issue       = (state_q == StRun) && !halt_req && !redirect_en && !skid_v
                         && !(pend_q && inst_valid && !inst_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StRst;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            count_q   <= '0;
        end else begin
            count_q <= count_q + 32'(transfer);
            pend_q  <= issue;
            if (issue) begin
                pend_pc_q <= pc_q;
                pc_q      <= pc_q + ADDR_W'(1);
            end
            if (redirect_en) begin
                pc_q    <= redirect_pc;
                state_q <= StRun;
            end else begin
                case (state_q)
                    StRst:   state_q <= StRun;
                    StRun:   if (halt_req) state_q <= StHalt;
                    StHalt:  state_q <= StHalt;
                    default: state_q <= StRst;
                endcase
            end
        end
    end

    fetch_skid_buf #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W)
    ) u_skid_buf (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (redirect_en),
        .in_valid_i  (resp_valid),
        .in_data_i   (q_imem),
        .in_pc_i     (pend_pc_q),
        .out_valid_o (inst_valid),
        .out_data_o  (inst_out),
        .out_pc_o    (inst_pc),
        .out_ready_i (inst_ready),
        .skid_valid_o(skid_v)
    );

    assign address_imem = pc_q;
    assign halted       = (state_q == StHalt);
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem[a] = a + 100, sequences checked against
// hand-derived PC orderings and cycle positions.
module tb_fetch_stage;

    localparam int unsigned AW = 12;
    localparam int unsigned IW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address_imem;
    logic [IW-1:0] q_imem;
    logic [IW-1:0] inst_out;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          inst_ready = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt_req = 1'b0;
    logic          halted;
    logic [31:0]   fetch_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt;

    fetch_stage #(
        .ADDR_W  (AW),
        .INST_W  (IW),
        .RESET_PC(12'h000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address_imem  (address_imem),
        .q_imem        (q_imem),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) q_imem <= {20'b0, address_imem} + 32'd100;

    // Transfer-count model: one per valid&&ready edge, cleared by reset.
    always @(posedge clock or posedge reset) begin
        if (reset) exp_cnt <= '0;
        else if (inst_valid && inst_ready) exp_cnt <= exp_cnt + 32'd1;
    end

    function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
        return {20'b0, a} + 32'd100;
    endfunction

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 12'h0) begin
            errors++;
            $display("FAIL reset_out: valid=%b out=%h pc=%h, required 0/0/0",
                     inst_valid, inst_out, inst_pc);
        end
        checks++;
        if (address_imem !== 12'h0 || halted !== 1'b0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: addr=%h halted=%b count=%0d, required 0/0/0",
                     address_imem, halted, fetch_count);
        end
    endtask

    task automatic test_stream();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (inst_valid !== 1'b0 || address_imem !== 12'h000) begin
            errors++;
            $display("FAIL rst_exit: valid=%b addr=%h, required 0/000", inst_valid, address_imem);
        end
        @(negedge clock);
        checks++;
        if (inst_valid !== 1'b0 || address_imem !== 12'h001) begin
            errors++;
            $display("FAIL first_issue: valid=%b addr=%h, required 0/001",
                     inst_valid, address_imem);
        end
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== AW'(i) || inst_out !== mem_val(AW'(i))) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b pc=%h out=%0d, required 1/%h/%0d", i,
                         inst_valid, inst_pc, inst_out, AW'(i), mem_val(AW'(i)));
            end
            @(negedge clock);
        end
    endtask

    // Entered with pc 6 on the output, 7 in flight and address 8.
    task automatic test_stall();
        logic [AW-1:0] e;
        int cyc;
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 12'h006 || inst_out !== 32'd106
                || address_imem !== 12'h008) begin
                errors++;
                $display("FAIL stall[%0d]: valid=%b pc=%h out=%0d addr=%h, required 1/006/106/008",
                         i, inst_valid, inst_pc, inst_out, address_imem);
            end
        end
        inst_ready = 1'b1;
        e = 12'h006;
        cyc = 0;
        while (e != 12'h00C && cyc < 40) begin
            if (inst_valid) begin
                checks++;
                if (inst_pc !== e || inst_out !== mem_val(e)) begin
                    errors++;
                    $display("FAIL stall_resume: pc=%h out=%0d, required %h/%0d",
                             inst_pc, inst_out, e, mem_val(e));
                end
                e++;
            end
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (e !== 12'h00C || fetch_count !== exp_cnt) begin
            errors++;
            $display("FAIL stall_drain: next=%h count=%0d, required 00c/%0d", e, fetch_count, exp_cnt);
        end
    endtask

    task automatic test_redirect();
        logic [AW-1:0] e;
        int cyc;
        inst_ready = 1'b0;
        repeat (3) @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc = 12'h040;
        @(negedge clock);
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || address_imem !== 12'h040) begin
            errors++;
            $display("FAIL redir_squash: valid=%b addr=%h, required 0/040", inst_valid, address_imem);
        end
        @(negedge clock);
        checks++;
        if (inst_valid !== 1'b0 || address_imem !== 12'h041) begin
            errors++;
            $display("FAIL redir_issue: valid=%b addr=%h, required 0/041", inst_valid, address_imem);
        end
        @(negedge clock);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 12'h040 || inst_out !== 32'd164) begin
            errors++;
            $display("FAIL redir_first: valid=%b pc=%h out=%0d, required 1/040/164",
                     inst_valid, inst_pc, inst_out);
        end
        inst_ready = 1'b1;
        e = 12'h040;
        cyc = 0;
        while (e != 12'h043 && cyc < 30) begin
            if (inst_valid) begin
                checks++;
                if (inst_pc !== e || inst_out !== mem_val(e)) begin
                    errors++;
                    $display("FAIL redir_seq: pc=%h out=%0d, required %h/%0d",
                             inst_pc, inst_out, e, mem_val(e));
                end
                e++;
            end
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (e !== 12'h043) begin
            errors++;
            $display("FAIL redir_timeout: next=%h, required 043", e);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] e;
        int cyc;
        redirect_valid = 1'b1;
        redirect_pc = 12'hFFD;
        @(negedge clock);
        redirect_valid = 1'b0;
        e = 12'hFFD;
        cyc = 0;
        while (e != 12'h002 && cyc < 30) begin
            if (inst_valid) begin
                checks++;
                if (inst_pc !== e || inst_out !== mem_val(e)) begin
                    errors++;
                    $display("FAIL wrap_seq: pc=%h out=%0d, required %h/%0d",
                             inst_pc, inst_out, e, mem_val(e));
                end
                e++;
            end
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (e !== 12'h002) begin
            errors++;
            $display("FAIL wrap_timeout: next=%h, required 002", e);
        end
    endtask

    task automatic test_halt();
        logic [AW-1:0] e;
        logic sent;
        int cyc;
        redirect_valid = 1'b1;
        redirect_pc = 12'h000;
        @(negedge clock);
        redirect_valid = 1'b0;
        e = 12'h000;
        sent = 1'b0;
        for (cyc = 0; cyc < 20; cyc++) begin
            if (inst_valid) begin
                checks++;
                if (inst_pc !== e || inst_out !== mem_val(e)) begin
                    errors++;
                    $display("FAIL halt_seq: pc=%h out=%0d, required %h/%0d",
                             inst_pc, inst_out, e, mem_val(e));
                end
                e++;
            end
            if (!sent && address_imem == 12'h005) begin
                halt_req = 1'b1;
                sent = 1'b1;
                @(negedge clock);
                halt_req = 1'b0;
                checks++;
                if (halted !== 1'b1) begin
                    errors++;
                    $display("FAIL halt_enter: halted=%b, required 1", halted);
                end
            end else begin
                @(negedge clock);
            end
        end
        checks++;
        if (e !== 12'h005 || halted !== 1'b1 || inst_valid !== 1'b0 || address_imem !== 12'h005) begin
            errors++;
            $display("FAIL halt_drain: next=%h halted=%b valid=%b addr=%h, required 005/1/0/005",
                     e, halted, inst_valid, address_imem);
        end
        redirect_valid = 1'b1;
        redirect_pc = 12'h010;
        @(negedge clock);
        redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0 || address_imem !== 12'h010) begin
            errors++;
            $display("FAIL halt_exit: halted=%b addr=%h, required 0/010", halted, address_imem);
        end
        e = 12'h010;
        cyc = 0;
        while (e != 12'h013 && cyc < 30) begin
            if (inst_valid) begin
                checks++;
                if (inst_pc !== e || inst_out !== mem_val(e)) begin
                    errors++;
                    $display("FAIL halt_resume: pc=%h out=%0d, required %h/%0d",
                             inst_pc, inst_out, e, mem_val(e));
                end
                e++;
            end
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (e !== 12'h013 || fetch_count !== exp_cnt) begin
            errors++;
            $display("FAIL halt_count: next=%h count=%0d, required 013/%0d", e, fetch_count, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [AW-1:0] e;
        int cyc;
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: valid=%b, required 1", inst_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 12'h0
            || address_imem !== 12'h000 || halted !== 1'b0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL areset_out: valid=%b out=%h pc=%h addr=%h halted=%b count=%0d, required all 0",
                     inst_valid, inst_out, inst_pc, address_imem, halted, fetch_count);
        end
        @(negedge clock);
        reset = 1'b0;
        e = 12'h000;
        cyc = 0;
        while (e != 12'h003 && cyc < 30) begin
            if (inst_valid) begin
                checks++;
                if (inst_pc !== e || inst_out !== mem_val(e)) begin
                    errors++;
                    $display("FAIL areset_restart: pc=%h out=%0d, required %h/%0d",
                             inst_pc, inst_out, e, mem_val(e));
                end
                e++;
            end
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (e !== 12'h003 || fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL areset_count: next=%h count=%0d, required 003/3", e, fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

endmodule
